memory_arbiter_burst: RTL and testbench

- Parametrised successor to the basic scratchpad/cache memory arbiter.
- Arbitrates a single-port RAM between four requesters: scratchpad row-burst loads, scratchpad row stores, dcache and icache.
- Scratchpad bursts of configurable geometry are packed into full rows; a fairness counter guarantees caches are served after a bounded number of scratchpad grants.
- Sits between the scratchpad/cache front ends and the RAM model.

---
 rtl/memory_arbiter_burst_if.sv | 51 +++++
 rtl/memory_arbiter_burst.sv | 177 +++++++++++++++++
 tb/tb_memory_arbiter_burst.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_burst_if.sv
// Bus bundle between the scratchpad/cache front ends, the burst memory arbiter and the RAM.
// slave is the arbiter side; master is the front-end / RAM-model side.
interface memory_arbiter_burst_if #(
    parameter int DATA_W    = 32,
    parameter int ROW_WORDS = 2,
    parameter int ROWS      = 4
);
    localparam int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                        sp_load;
    logic [31:0]                 sp_load_addr;
    logic                        sp_load_hit;
    logic [ROW_IDX_W-1:0]        sp_load_row;
    logic [ROW_WORDS*DATA_W-1:0] sp_load_data;
    logic                        sp_store;
    logic [31:0]                 sp_store_addr;
    logic [ROW_WORDS*DATA_W-1:0] sp_store_data;
    logic                        sp_store_hit;
    logic                        dREN;
    logic                        dWEN;
    logic [31:0]                 daddr;
    logic [DATA_W-1:0]           dstore;
    logic [DATA_W-1:0]           dload;
    logic                        dwait;
    logic                        iREN;
    logic [31:0]                 iaddr;
    logic [DATA_W-1:0]           iload;
    logic                        iwait;
    logic                        ram_ren;
    logic                        ram_wen;
    logic [31:0]                 ram_addr;
    logic [DATA_W-1:0]           ram_store;
    logic [DATA_W-1:0]           ram_load;
    logic [1:0]                  ram_state;

    modport slave (
        input  sp_load, sp_load_addr, sp_store, sp_store_addr, sp_store_data,
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ram_load, ram_state,
        output sp_load_hit, sp_load_row, sp_load_data, sp_store_hit,
        output dload, dwait, iload, iwait,
        output ram_ren, ram_wen, ram_addr, ram_store
    );

    modport master (
        output sp_load, sp_load_addr, sp_store, sp_store_addr, sp_store_data,
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ram_load, ram_state,
        input  sp_load_hit, sp_load_row, sp_load_data, sp_store_hit,
        input  dload, dwait, iload, iwait,
        input  ram_ren, ram_wen, ram_addr, ram_store
    );
endinterface

// File: rtl/memory_arbiter_burst.sv
// Single-port RAM arbiter for scratchpad row bursts, scratchpad row stores, dcache and icache,
// with a grant counter that forces pending cache requests ahead of long scratchpad streams.
module memory_arbiter_burst #(
    parameter int DATA_W        = 32,
    parameter int ROW_WORDS     = 2,
    parameter int ROWS          = 4,
    parameter int ROW_STRIDE    = 8,
    parameter int WORD_BYTES    = 4,
    parameter int MAX_SP_GRANTS = 4
) (
    input logic                   CLK,
    input logic                   nRST,
    memory_arbiter_burst_if.slave bus
);
    localparam int WIDX_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W  = (MAX_SP_GRANTS > 0) ? $clog2(MAX_SP_GRANTS + 1) : 1;
    localparam int ROW_W  = ROW_WORDS * DATA_W;

    localparam logic [WIDX_W-1:0] LAST_W   = WIDX_W'(ROW_WORDS - 1);
    localparam logic [RIDX_W-1:0] LAST_R   = RIDX_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'((MAX_SP_GRANTS > 0) ? MAX_SP_GRANTS : 1);
    localparam bit                GUARD_EN = (MAX_SP_GRANTS != 0);
    localparam logic [1:0]        ACCESS   = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        SP_LOAD,
        SP_STORE,
        DCACHE,
        ICACHE
    } state_t;

    state_t              state;
    logic [WIDX_W-1:0]   w;
    logic [RIDX_W-1:0]   r;
    logic [CNT_W-1:0]    sp_cnt;
    logic [ROW_W-1:0]    row_buf;
    logic [ROW_W-1:0]    row_next;
    logic                load_hit;
    logic [RIDX_W-1:0]   load_row;
    logic [ROW_W-1:0]    load_data;
    logic                store_hit;
    logic                dc_req;
    logic                force_cache;
    logic                access;

    assign access      = (bus.ram_state == ACCESS);
    assign dc_req      = bus.dREN | bus.dWEN;
    assign force_cache = GUARD_EN && (sp_cnt == CNT_SAT) && (dc_req || bus.iREN);

    assign bus.sp_load_hit  = load_hit;
    assign bus.sp_load_row  = load_row;
    assign bus.sp_load_data = load_data;
    assign bus.sp_store_hit = store_hit;

    // RAM strobes, addresses and cache returns follow the owning state only
    always_comb begin
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;
        bus.dload     = '0;
        bus.iload     = '0;
        bus.dwait     = 1'b1;
        bus.iwait     = 1'b1;
        row_next      = row_buf;
        row_next[32'(w)*DATA_W +: DATA_W] = bus.ram_load;
        case (state)
            SP_LOAD: begin
                bus.ram_ren  = 1'b1;
                bus.ram_addr = bus.sp_load_addr + 32'(r) * 32'(ROW_STRIDE)
                             + 32'(w) * 32'(WORD_BYTES);
            end
            SP_STORE: begin
                bus.ram_wen   = 1'b1;
                bus.ram_addr  = bus.sp_store_addr + 32'(w) * 32'(WORD_BYTES);
                bus.ram_store = bus.sp_store_data[32'(w)*DATA_W +: DATA_W];
            end
            DCACHE: begin
                bus.ram_wen   = bus.dWEN;
                bus.ram_ren   = bus.dREN & ~bus.dWEN;
                bus.ram_addr  = bus.daddr;
                bus.ram_store = bus.dstore;
                bus.dload     = bus.ram_load;
                bus.dwait     = ~access;
            end
            ICACHE: begin
                bus.ram_ren  = 1'b1;
                bus.ram_addr = bus.iaddr;
                bus.iload    = bus.ram_load;
                bus.iwait    = ~access;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            w         <= '0;
            r         <= '0;
            sp_cnt    <= '0;
            row_buf   <= '0;
            load_hit  <= 1'b0;
            load_row  <= '0;
            load_data <= '0;
            store_hit <= 1'b0;
        end else begin
            load_hit  <= 1'b0;
            store_hit <= 1'b0;
            case (state)
                IDLE: begin
                    w <= '0;
                    r <= '0;
                    if (force_cache) begin
                        state  <= dc_req ? DCACHE : ICACHE;
                        sp_cnt <= '0;
                    end else if (bus.sp_load) begin
                        state <= SP_LOAD;
                    end else if (bus.sp_store) begin
                        state <= SP_STORE;
                    end else if (dc_req) begin
                        state  <= DCACHE;
                        sp_cnt <= '0;
                    end else if (bus.iREN) begin
                        state  <= ICACHE;
                        sp_cnt <= '0;
                    end
                end
                SP_LOAD: begin
                    if (!bus.sp_load) begin
                        state <= IDLE;
                        w     <= '0;
                        r     <= '0;
                    end else if (access) begin
                        row_buf <= row_next;
                        if (w == LAST_W) begin
                            w         <= '0;
                            load_hit  <= 1'b1;
                            load_row  <= r;
                            load_data <= row_next;
                            if (r == LAST_R) begin
                                state <= IDLE;
                                r     <= '0;
                                if (sp_cnt != CNT_SAT) sp_cnt <= sp_cnt + 1'b1;
                            end else begin
                                r <= r + 1'b1;
                            end
                        end else begin
                            w <= w + 1'b1;
                        end
                    end
                end
                SP_STORE: begin
                    if (!bus.sp_store) begin
                        state <= IDLE;
                        w     <= '0;
                    end else if (access) begin
                        if (w == LAST_W) begin
                            w         <= '0;
                            store_hit <= 1'b1;
                            state     <= IDLE;
                            if (sp_cnt != CNT_SAT) sp_cnt <= sp_cnt + 1'b1;
                        end else begin
                            w <= w + 1'b1;
                        end
                    end
                end
                // an in-flight icache access is never pre-empted by the dcache
                DCACHE: if (access || !dc_req) state <= IDLE;
                ICACHE: if (access || !bus.iREN) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter_burst.sv
// Directed and randomised bench for memory_arbiter_burst against a transaction-level model
// of the expected RAM access sequence, row hits and cache return values.
module tb_memory_arbiter_burst;
    localparam int DATA_W     = 32;
    localparam int ROW_WORDS  = 2;
    localparam int ROWS       = 4;
    localparam int ROW_STRIDE = 8;
    localparam int WORD_BYTES = 4;
    localparam int MAXG       = 2;

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; int cyc; } acc_t;
    typedef struct { int cyc; logic [1:0] row; logic [63:0] data; } hit_t;
    typedef struct { logic [1:0] row; logic [63:0] data; int idx; } ehit_t;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    memory_arbiter_burst_if #(.DATA_W(DATA_W), .ROW_WORDS(ROW_WORDS), .ROWS(ROWS)) bus ();

    memory_arbiter_burst #(
        .DATA_W(DATA_W), .ROW_WORDS(ROW_WORDS), .ROWS(ROWS), .ROW_STRIDE(ROW_STRIDE),
        .WORD_BYTES(WORD_BYTES), .MAX_SP_GRANTS(MAXG)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bus)
    );

    logic [DATA_W-1:0] mem     [0:1023];
    logic [DATA_W-1:0] ref_mem [0:1023];
    acc_t  acc_log[$];
    acc_t  exp_acc[$];
    hit_t  ld_hits[$];
    ehit_t exp_ld[$];
    int    st_cyc[$];
    int    exp_st[$];
    int    cyc = 0;
    int    ram_mode = 0;
    int    checks = 0;
    int    errors = 0;

    assign bus.ram_load = mem[bus.ram_addr[11:2]];

    // RAM responder: ram_state changes just after each rising edge
    initial begin
        bus.ram_state = 2'd0;
        forever begin
            @(posedge CLK);
            #1;
            cyc = cyc + 1;
            if (ram_mode == 0) bus.ram_state = (cyc % 2 == 0) ? 2'd2 : 2'd1;
            else               bus.ram_state = 2'($urandom_range(0, 3));
        end
    end

    // RAM write port and observation log, sampled mid-cycle
    initial begin
        forever begin
            @(negedge CLK);
            if (nRST && bus.ram_state == 2'd2 && (bus.ram_ren || bus.ram_wen)) begin
                acc_log.push_back('{bus.ram_wen, bus.ram_addr,
                                    bus.ram_wen ? bus.ram_store : bus.ram_load, cyc});
                if (bus.ram_wen) mem[bus.ram_addr[11:2]] = bus.ram_store;
            end
            if (bus.sp_load_hit) ld_hits.push_back('{cyc, bus.sp_load_row, bus.sp_load_data});
            if (bus.sp_store_hit) st_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete(); exp_acc.delete(); ld_hits.delete();
        exp_ld.delete(); st_cyc.delete(); exp_st.delete();
    endtask

    task automatic reset_dut();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic exp_rd(input logic [31:0] a, output logic [31:0] v);
        v = ref_mem[a[11:2]];
        exp_acc.push_back('{1'b0, a, v, 0});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        ref_mem[a[11:2]] = d;
        exp_acc.push_back('{1'b1, a, d, 0});
    endtask

    task automatic exp_load(input logic [31:0] base, input int nrows);
        logic [31:0] v;
        logic [63:0] row;
        for (int rr = 0; rr < nrows; rr++) begin
            row = '0;
            for (int ww = 0; ww < ROW_WORDS; ww++) begin
                exp_rd(base + 32'(rr * ROW_STRIDE + ww * WORD_BYTES), v);
                row[ww*DATA_W +: DATA_W] = v;
            end
            exp_ld.push_back('{2'(rr), row, exp_acc.size() - 1});
        end
    endtask

    task automatic exp_store(input logic [31:0] a, input logic [63:0] d);
        for (int ww = 0; ww < ROW_WORDS; ww++)
            exp_wr(a + 32'(ww * WORD_BYTES), d[ww*DATA_W +: DATA_W]);
        exp_st.push_back(exp_acc.size() - 1);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_nacc"}, 64'(acc_log.size()), 64'(exp_acc.size()));
        if (acc_log.size() == exp_acc.size()) begin
            for (int i = 0; i < acc_log.size(); i++) begin
                check({tag, "_acc_op"}, {31'd0, acc_log[i].wr, acc_log[i].addr},
                      {31'd0, exp_acc[i].wr, exp_acc[i].addr});
                check({tag, "_acc_data"}, 64'(acc_log[i].data), 64'(exp_acc[i].data));
            end
        end
        check({tag, "_nldhit"}, 64'(ld_hits.size()), 64'(exp_ld.size()));
        if (ld_hits.size() == exp_ld.size()) begin
            for (int i = 0; i < ld_hits.size(); i++) begin
                check({tag, "_row"}, 64'(ld_hits[i].row), 64'(exp_ld[i].row));
                check({tag, "_rowdata"}, ld_hits[i].data, exp_ld[i].data);
                if (exp_ld[i].idx < acc_log.size())
                    check({tag, "_ldhit_cyc"}, 64'(ld_hits[i].cyc),
                          64'(acc_log[exp_ld[i].idx].cyc + 1));
            end
        end
        check({tag, "_nsthit"}, 64'(st_cyc.size()), 64'(exp_st.size()));
        if (st_cyc.size() == exp_st.size()) begin
            for (int i = 0; i < st_cyc.size(); i++)
                if (exp_st[i] < acc_log.size())
                    check({tag, "_sthit_cyc"}, 64'(st_cyc[i]), 64'(acc_log[exp_st[i]].cyc + 1));
        end
    endtask

    task automatic do_load(input logic [31:0] base, input int nrows);
        int n0 = ld_hits.size();
        bit ok = 1'b0;
        bus.sp_load_addr = base;
        bus.sp_load = 1'b1;
        for (int c = 0; c < 800; c++) begin
            tick();
            if (ld_hits.size() >= n0 + nrows) begin ok = 1'b1; break; end
        end
        bus.sp_load = 1'b0;
        check("load_done", 64'(ok), 64'd1);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [63:0] d);
        int n0 = st_cyc.size();
        bit ok = 1'b0;
        bus.sp_store_addr = a;
        bus.sp_store_data = d;
        bus.sp_store = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (st_cyc.size() > n0) begin ok = 1'b1; break; end
        end
        bus.sp_store = 1'b0;
        check("store_done", 64'(ok), 64'd1);
    endtask

    task automatic do_dc(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] v);
        bit ok = 1'b0;
        v = '0;
        bus.daddr = a;
        bus.dstore = d;
        bus.dWEN = wr;
        bus.dREN = ~wr;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!bus.dwait) begin v = bus.dload; ok = 1'b1; break; end
        end
        bus.dWEN = 1'b0;
        bus.dREN = 1'b0;
        check("dc_done", 64'(ok), 64'd1);
    endtask

    task automatic do_ic(input logic [31:0] a, output logic [31:0] v);
        bit ok = 1'b0;
        v = '0;
        bus.iaddr = a;
        bus.iREN = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!bus.iwait) begin v = bus.iload; ok = 1'b1; break; end
        end
        bus.iREN = 1'b0;
        check("ic_done", 64'(ok), 64'd1);
    endtask

    initial begin
        logic [31:0] dv, iv, dgot, igot, a, d32;
        logic [63:0] d64;
        bit ld_done, d_done, i_done, i_early, ok, wr;
        int kind;

        bus.sp_load = 0; bus.sp_load_addr = 0; bus.sp_store = 0; bus.sp_store_addr = 0;
        bus.sp_store_data = 0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
        bus.iREN = 0; bus.iaddr = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end

        nRST = 1'b0;
        repeat (3) tick();
        check("rst_dwait", 64'(bus.dwait), 64'd1);
        check("rst_iwait", 64'(bus.iwait), 64'd1);
        check("rst_strobes", {62'd0, bus.ram_ren, bus.ram_wen}, 64'd0);
        check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
        check("rst_hits", {62'd0, bus.sp_load_hit, bus.sp_store_hit}, 64'd0);
        check("rst_row_data", bus.sp_load_data, 64'd0);
        check("rst_cache_data", {bus.dload, bus.iload}, 64'd0);
        nRST = 1'b1;
        tick();

        // load burst, RAM completes every second cycle
        clear_logs();
        exp_load(32'h100, ROWS);
        do_load(32'h100, ROWS);
        repeat (6) tick();
        check_all("load");

        reset_dut();
        clear_logs();
        exp_store(32'h40, 64'hDEADBEEF_CAFEF00D);
        do_store(32'h40, 64'hDEADBEEF_CAFEF00D);
        repeat (6) tick();
        check_all("store");
        check("store_mem_lo", 64'(mem[32'h40 >> 2]), 64'hCAFEF00D);
        check("store_mem_hi", 64'(mem[32'h44 >> 2]), 64'hDEADBEEF);

        // burst abandoned after the row 1 hit, then restarted elsewhere
        reset_dut();
        clear_logs();
        exp_load(32'h100, 2);
        do_load(32'h100, 2);
        repeat (12) tick();
        check_all("abort");
        clear_logs();
        exp_load(32'h200, ROWS);
        do_load(32'h200, ROWS);
        repeat (4) tick();
        check_all("restart");

        // continuous stores versus a dcache read
        reset_dut();
        clear_logs();
        ram_mode = 1;
        d64 = {$urandom, $urandom};
        exp_store(32'h40, d64);
        exp_store(32'h40, d64);
        exp_rd(32'h80, dv);
        exp_store(32'h40, d64);
        bus.sp_store_addr = 32'h40;
        bus.sp_store_data = d64;
        bus.sp_store = 1'b1;
        bus.daddr = 32'h80;
        bus.dREN = 1'b1;
        d_done = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (!d_done && !bus.dwait) begin
                check("fair_hits_before_d", 64'(st_cyc.size()), 64'd2);
                check("fair_dload", 64'(bus.dload), 64'(dv));
                bus.dREN = 1'b0;
                d_done = 1'b1;
            end
            if (st_cyc.size() >= 3) begin ok = 1'b1; break; end
        end
        bus.sp_store = 1'b0;
        bus.dREN = 1'b0;
        check("fair_done", {62'd0, ok, d_done}, 64'd3);
        repeat (4) tick();
        check_all("fair");

        // three requesters raised together
        reset_dut();
        clear_logs();
        exp_load(32'h300, ROWS);
        exp_rd(32'h84, dv);
        exp_rd(32'h88, iv);
        bus.sp_load_addr = 32'h300;
        bus.daddr = 32'h84;
        bus.iaddr = 32'h88;
        bus.sp_load = 1'b1;
        bus.dREN = 1'b1;
        bus.iREN = 1'b1;
        ld_done = 0; d_done = 0; i_done = 0; i_early = 0; dgot = '0; igot = '0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (!ld_done && ld_hits.size() >= ROWS) begin bus.sp_load = 1'b0; ld_done = 1'b1; end
            if (!d_done && !bus.dwait) begin
                dgot = bus.dload;
                bus.dREN = 1'b0;
                d_done = 1'b1;
            end
            if (!i_done && !bus.iwait) begin
                igot = bus.iload;
                bus.iREN = 1'b0;
                i_done = 1'b1;
                if (!d_done || !ld_done) i_early = 1'b1;
            end
            if (i_done) break;
        end
        bus.sp_load = 1'b0; bus.dREN = 1'b0; bus.iREN = 1'b0;
        check("three_done", {61'd0, ld_done, d_done, i_done}, 64'd7);
        check("three_iwait_held", 64'(i_early), 64'd0);
        check("three_dload", 64'(dgot), 64'(dv));
        check("three_iload", 64'(igot), 64'(iv));
        repeat (4) tick();
        check_all("three");

        // asynchronous reset during row 1, word 1
        reset_dut();
        clear_logs();
        ram_mode = 0;
        bus.sp_load_addr = 32'h100;
        bus.sp_load = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (bus.ram_ren && bus.ram_addr == 32'h10C) begin ok = 1'b1; break; end
        end
        check("rstmid_reached", 64'(ok), 64'd1);
        nRST = 1'b0;
        #1;
        check("rstmid_waits", {62'd0, bus.dwait, bus.iwait}, 64'd3);
        check("rstmid_strobes", {62'd0, bus.ram_ren, bus.ram_wen}, 64'd0);
        check("rstmid_row_data", bus.sp_load_data, 64'd0);
        check("rstmid_row", 64'(bus.sp_load_row), 64'd0);
        bus.sp_load = 1'b0;
        tick();
        nRST = 1'b1;
        repeat (5) tick();
        check("rstmid_hits", 64'(ld_hits.size()), 64'd1);
        check("rstmid_idle", {62'd0, bus.ram_ren, bus.ram_wen}, 64'd0);

        // randomised single transactions with random RAM latency
        reset_dut();
        clear_logs();
        ram_mode = 1;
        for (int it = 0; it < 12; it++) begin
            kind = int'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 200)) * 32'd4;
            case (kind)
                0: begin
                    exp_load(a, ROWS);
                    do_load(a, ROWS);
                end
                1: begin
                    d64 = {$urandom, $urandom};
                    exp_store(a, d64);
                    do_store(a, d64);
                end
                2: begin
                    wr = 1'($urandom_range(0, 1));
                    d32 = $urandom;
                    if (wr) exp_wr(a, d32);
                    else    exp_rd(a, dv);
                    do_dc(wr, a, d32, dgot);
                    if (!wr) check("rand_dload", 64'(dgot), 64'(dv));
                end
                default: begin
                    exp_rd(a, iv);
                    do_ic(a, igot);
                    check("rand_iload", 64'(igot), 64'(iv));
                end
            endcase
        end
        repeat (4) tick();
        check_all("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
